// File: rtl/moore_seq_detector_param.sv
// Parametrised Moore serial sequence detector with a runtime-loadable pattern,
// overlap/non-overlap selection, valid-qualified input and a saturating match counter.
//
//   state          | meaning
//   ---------------+-----------------------------------------------
//   S0             | no leading pattern bits matched
//   Sk (0<k<LEN)   | k leading pattern bits matched
//   DETECT (=LEN)  | full pattern seen; o_seq_detected = 1
module moore_seq_detector_param #(
    parameter int                 SEQ_LEN     = 4,
    parameter int                 CNT_W       = 8,
    parameter logic [SEQ_LEN-1:0] RST_PATTERN = 4'b1011
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_x,
    input  logic               i_valid,
    input  logic               i_load,
    input  logic [SEQ_LEN-1:0] i_pattern,
    input  logic               i_overlap,
    input  logic               i_clear,
    output logic               o_seq_detected,
    output logic [CNT_W-1:0]   o_match_count,
    output logic               o_count_sat
);

    localparam int SW = $clog2(SEQ_LEN + 1);
    typedef logic [SW-1:0] state_t;
    localparam state_t S0     = '0;
    localparam state_t DETECT = state_t'(SEQ_LEN);
    localparam logic [SEQ_LEN:0] ONE = (SEQ_LEN + 1)'(1);

    state_t               state_q, state_d;
    logic [SEQ_LEN-1:0]   pattern_q, pattern_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sat_q, sat_d;

    int                   keff;
    logic [SEQ_LEN:0]     hist;
    logic [SEQ_LEN:0]     pfx;
    logic [SEQ_LEN:0]     msk;
    state_t               match_len;
    logic                 hit;

    // History = matched prefix followed by i_x, right aligned; the longest
    // pattern prefix that is a suffix of it becomes the next state.
    always_comb begin
        keff      = (state_q == DETECT && !i_overlap) ? 0 : int'(state_q);
        hist      = (({1'b0, pattern_q} >> (SEQ_LEN - keff)) << 1) | {{SEQ_LEN{1'b0}}, i_x};
        pfx       = '0;
        msk       = '0;
        match_len = S0;
        for (int j = 1; j <= SEQ_LEN; j++) begin
            pfx = {1'b0, pattern_q} >> (SEQ_LEN - j);
            msk = (ONE << j) - ONE;
            if (j <= keff + 1 && (hist & msk) == pfx) begin
                match_len = state_t'(j);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        hit       = 1'b0;
        if (i_load) begin
            pattern_d = i_pattern;
            state_d   = S0;
        end else if (i_valid) begin
            state_d = match_len;
            hit     = (match_len == DETECT);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (i_clear) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else begin
            if (hit && cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
            sat_d = &cnt_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= S0;
            pattern_q <= RST_PATTERN;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
        end
    end

    assign o_seq_detected = (state_q == DETECT);
    assign o_match_count  = cnt_q;
    assign o_count_sat    = sat_q;

endmodule

// File: doc/moore_seq_detector_param.md
Name: moore_seq_detector_param

Overview:
- Parametrised Moore-style serial sequence detector; the next generation of the team's fixed-pattern, non-overlapping Moore detector.
- Sequence length is a parameter. The pattern is loadable at runtime, and overlap/non-overlap mode is selected by a pin.
- Input bits are qualified by a valid strobe. A saturating match counter is included.
- Sits on a 1-bit serial stream (e.g. a framing/sync-word search) ahead of a deserialiser or frame aligner.

Parameters:
- SEQ_LEN, 4, pattern length in bits (>=2).
- CNT_W, 8, width of the match counter.
- RST_PATTERN, 4'b1011, pattern loaded at reset (SEQ_LEN bits). MSB is the first bit expected on the wire.

Ports:
- i_clk  in  1  system clock; all state updates on its rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_x  in  1  serial data bit.
- i_valid  in  1  i_x is consumed only on edges where i_valid=1.
- i_load  in  1  single-cycle pulse: load i_pattern and restart the search.
- i_pattern  in  SEQ_LEN  new pattern, MSB first on the wire.
- i_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- i_clear  in  1  synchronous clear of the match counter.
- o_seq_detected  out  1  high while the FSM is in state DETECT.
- o_match_count  out  CNT_W  number of detections since reset/clear; saturating.
- o_count_sat  out  1  high while o_match_count is all ones.

Behaviour:
- Reset (i_reset=0, asynchronous): state=S0, pattern=RST_PATTERN, o_seq_detected=0, o_match_count=0, o_count_sat=0.
- States S0..S(SEQ_LEN-1) mean "k leading pattern bits matched". State S(SEQ_LEN) is DETECT. State register width = clog2(SEQ_LEN+1).
- Moore output: o_seq_detected = (state==DETECT), decoded from the registered state only. The last pattern bit sampled at edge k gives o_seq_detected=1 from just after edge k until the next state change (1-clock latency).
- On an edge with i_valid=1 and i_load=0:
  - Form history = (prefix of k matched bits) followed by i_x.
  - Next state = length of the longest pattern prefix that is a suffix of history (KMP fallback), evaluated combinationally over all candidate lengths.
- From DETECT:
  - i_overlap=1: history = the full pattern plus i_x, so overlapping matches chain.
  - i_overlap=0: history = i_x only. The next state is S1 if i_x equals pattern MSB, else S0.
  - i_overlap is sampled on every valid edge and only affects transitions out of DETECT.
- i_valid=0: state, pattern and counter hold; o_seq_detected holds its value.
- i_load=1 (priority over i_valid): pattern <= i_pattern, state <= S0, and i_x is ignored that cycle. o_seq_detected drops on the next edge. Counter is unaffected.
- Counter increments on every valid edge whose next state is DETECT, including DETECT->DETECT in overlap mode.
  - It saturates at 2^CNT_W-1; o_count_sat is registered and asserts together with the saturating value.
  - i_clear=1: counter <= 0 and o_count_sat <= 0. Clear wins over a simultaneous increment.
- Reset asserted mid-sequence: immediate return to reset values; any partial match is lost.
- No X propagation: i_x is ignored when i_valid=0, including when i_x is X.

Test Plan:
- Reset sequence: apply i_reset=0 with X on all inputs, then release. Required: o_seq_detected=0, o_match_count=0, state S0, pattern 1011.
- Overlap mode: pattern 1011, i_overlap=1, stream 1,0,1,1,0,1,1 (i_valid=1). Required: o_seq_detected high one cycle after bit 4 and again after bit 7; o_match_count=2.
- Non-overlap mode: the same stream with i_overlap=0. Required: single detect after bit 4; o_match_count=1.
- Load pattern 111 (SEQ_LEN=3 build) and drive six 1s:
  - Overlap: o_seq_detected high for 4 consecutive cycles after bit 3; count=4.
  - Non-overlap: pulses after bits 3 and 6 only; count=2.
- Valid gaps and load: stream 1,0,(i_valid=0 for 3 cycles),1,1. Required: detect after the last bit. Then pulse i_load with 0110 mid-match: state returns to S0, output low next edge, and 0,1,1,0 then detects.
- Counter: CNT_W=2 build, 5 detections. Required: o_match_count stops at 3 with o_count_sat=1. Then i_clear coinciding with a detection: count=0 and o_count_sat=0.
